// File: rtl/xoodoo_share_codec.sv
// xoodoo_share_codec: masks plaintext words into two DOM shares for Xoodoo and recombines the permuted shares one lane per cycle
// Ports: s_* plaintext word stream in (rnd = mask per accepted beat); sh_0/sh_1/sh_valid/sh_ack share pair to the permutation;
// perm_done/perm_0/perm_1 permuted shares back; m_* recombined word stream out; busy high outside IDLE; rst synchronous active-low.
module xoodoo_share_codec #(
  parameter int NW = 12,
  parameter int WW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WW-1:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WW-1:0]    rnd,
  output logic [NW*WW-1:0] sh_0,
  output logic [NW*WW-1:0] sh_1,
  output logic             sh_valid,
  input  logic             sh_ack,
  input  logic             perm_done,
  input  logic [NW*WW-1:0] perm_0,
  input  logic [NW*WW-1:0] perm_1,
  output logic [WW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy
);
  localparam int CW = $clog2(NW);
  typedef enum logic [2:0] {IDLE, LOAD, HAND, WAIT, DRAIN} state_e;
  state_e state_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic [WW-1:0] sh0_q [NW];
  logic [WW-1:0] sh1_q [NW];
  logic [WW-1:0] q0_q [NW];
  logic [WW-1:0] q1_q [NW];
  logic [WW-1:0] m_data_q;
  logic s_ready_q, sh_valid_q, m_valid_q, busy_q, last;
  assign cnt_inc = cnt_q + 1'b1;
  assign last = cnt_q == CW'(NW - 1);
  assign s_ready = s_ready_q;
  assign sh_valid = sh_valid_q;
  assign m_data = m_data_q;
  assign m_valid = m_valid_q;
  assign busy = busy_q;
  for (genvar i = 0; i < NW; i++) begin : g_lane
    assign sh_0[i*WW +: WW] = sh0_q[i];
    assign sh_1[i*WW +: WW] = sh1_q[i];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      for (int k = 0; k < NW; k++) begin
        sh0_q[k] <= '0;
        sh1_q[k] <= '0;
        q0_q[k] <= '0;
        q1_q[k] <= '0;
      end
      m_data_q <= '0;
      s_ready_q <= 1'b1;
      sh_valid_q <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, LOAD: if (s_valid) begin
          sh0_q[cnt_q] <= s_data ^ rnd;
          sh1_q[cnt_q] <= rnd;
          busy_q <= 1'b1;
          cnt_q <= last ? '0 : cnt_inc;
          state_q <= last ? HAND : LOAD;
          s_ready_q <= !last;
          sh_valid_q <= last;
        end
        HAND: if (sh_ack) begin
          sh_valid_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: if (perm_done) begin
          for (int k = 0; k < NW; k++) begin
            q0_q[k] <= perm_0[k*WW +: WW];
            q1_q[k] <= perm_1[k*WW +: WW];
            sh0_q[k] <= '0;
            sh1_q[k] <= '0;
          end
          // lane 0 is recombined straight off the capture edge so the first word appears one cycle after perm_done
          m_data_q <= perm_0[WW-1:0] ^ perm_1[WW-1:0];
          m_valid_q <= 1'b1;
          state_q <= DRAIN;
        end
        DRAIN: if (m_ready) begin
          if (last) begin
            for (int k = 0; k < NW; k++) begin
              q0_q[k] <= '0;
              q1_q[k] <= '0;
            end
            m_data_q <= '0;
            m_valid_q <= 1'b0;
            cnt_q <= '0;
            busy_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            m_data_q <= q0_q[cnt_inc] ^ q1_q[cnt_inc];
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xoodoo_share_codec.sv
// tb_xoodoo_share_codec: random self-checking bench for xoodoo_share_codec
module tb_xoodoo_share_codec;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] s_data = '0, rnd = '0, m_data;
  logic s_valid = 1'b0, s_ready, sh_valid, sh_ack = 1'b0, perm_done = 1'b0, m_valid, m_ready = 1'b0, busy;
  logic [383:0] sh_0, sh_1, perm_0 = '0, perm_1 = '0;
  logic [31:0] w [12];
  logic [31:0] r [12];
  logic [31:0] x [12];
  logic [31:0] y [12];
  int checks = 0, errors = 0;

  xoodoo_share_codec dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .rnd(rnd),
    .sh_0(sh_0), .sh_1(sh_1), .sh_valid(sh_valid), .sh_ack(sh_ack),
    .perm_done(perm_done), .perm_0(perm_0), .perm_1(perm_1),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [383:0] pack(input logic [31:0] a [12]);
    logic [383:0] v;
    for (int k = 0; k < 12; k++) v[k*32 +: 32] = a[k];
    return v;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] v;
    for (int k = 0; k < 12; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic randomize_words();
    for (int k = 0; k < 12; k++) begin
      w[k] = $urandom;
      r[k] = $urandom;
      x[k] = $urandom;
      y[k] = $urandom;
    end
  endtask

  task automatic load(input int n, input bit gaps);
    logic [31:0] e0 [12];
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        s_data = $urandom;
        perm_done = 1'($urandom);
        sh_ack = 1'($urandom);
        tick();
      end
      perm_done = 1'b0;
      sh_ack = 1'b0;
      s_valid = 1'b1;
      s_data = w[k];
      rnd = r[k];
      chk("s_ready_load", 384'(s_ready), 384'(1));
      chk("sh_valid_early", 384'(sh_valid), 384'(0));
      tick();
    end
    s_valid = 1'b0;
    rnd = $urandom;
    if (n == 12) begin
      for (int k = 0; k < 12; k++) e0[k] = w[k] ^ r[k];
      chk("sh_valid_rise", 384'(sh_valid), 384'(1));
      chk("s_ready_drop", 384'(s_ready), 384'(0));
      chk("sh_0", sh_0, pack(e0));
      chk("sh_1", sh_1, pack(r));
    end
  endtask

  task automatic do_perm(input bit spur);
    if (spur) repeat (3) begin
      perm_done = 1'b1;
      perm_0 = rand384();
      perm_1 = rand384();
      tick();
      chk("hand_hold_valid", 384'(sh_valid), 384'(1));
      chk("hand_no_drain", 384'(m_valid), 384'(0));
    end
    perm_done = 1'b0;
    sh_ack = 1'b1;
    tick();
    sh_ack = 1'b0;
    chk("sh_valid_drop", 384'(sh_valid), 384'(0));
    if (spur) repeat (2) begin
      sh_ack = 1'b1;
      tick();
      chk("wait_no_drain", 384'(m_valid), 384'(0));
    end
    sh_ack = 1'b0;
    perm_0 = pack(x);
    perm_1 = pack(x) ^ pack(y);
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    perm_0 = rand384();
    perm_1 = rand384();
    chk("m_valid_latency", 384'(m_valid), 384'(1));
    chk("sh_0_zeroized", sh_0, '0);
    chk("sh_1_zeroized", sh_1, '0);
  endtask

  task automatic drain(input int n, input bit bp);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 400) begin
      m_ready = bp ? 1'($urandom) : 1'b1;
      chk("m_valid_drain", 384'(m_valid), 384'(1));
      chk("busy_drain", 384'(busy), 384'(1));
      chk($sformatf("m_data_lane%0d", k), 384'(m_data), 384'(y[k]));
      tick();
      if (m_ready) k++;
      cyc++;
    end
    m_ready = 1'b0;
    chk("drain_count", 384'(k), 384'(n));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_m_valid"}, 384'(m_valid), 384'(0));
    chk({tag, "_m_data"}, 384'(m_data), 384'(0));
    chk({tag, "_busy"}, 384'(busy), 384'(0));
    chk({tag, "_s_ready"}, 384'(s_ready), 384'(1));
    chk({tag, "_sh_valid"}, 384'(sh_valid), 384'(0));
    chk({tag, "_sh_0"}, sh_0, '0);
    chk({tag, "_sh_1"}, sh_1, '0);
  endtask

  task automatic full(input bit rand_mode);
    randomize_words();
    load(12, rand_mode);
    do_perm(rand_mode);
    drain(12, rand_mode);
    idle_chk("end");
  endtask

  initial begin
    tick();
    tick();
    idle_chk("reset");
    rst = 1'b1;
    randomize_words();
    for (int k = 0; k < 12; k++) begin
      w[k] = k;
      r[k] = 32'hA5A5A5A5;
    end
    load(12, 1'b0);
    do_perm(1'b0);
    drain(12, 1'b0);
    idle_chk("directed");
    repeat (3) full(1'b1);
    randomize_words();
    load(12, 1'b0);
    do_perm(1'b0);
    drain(5, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle_chk("rst_drain");
    full(1'b0);
    randomize_words();
    load(7, 1'b1);
    chk("busy_load", 384'(busy), 384'(1));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle_chk("rst_load");
    full(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
